// File: rtl/ram_refresh_arbiter_pkg.sv
// Shared types and default DRAM timing for the RAM/refresh arbiter.
// Holds the FSM state encoding and the fixed arbitration priority.
package ram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC_RAS = 3'd1,
    ACC_CAS = 3'd2,
    REF_CAS = 3'd3,
    REF_RAS = 3'd4,
    PRE     = 3'd5
  } ramState_t;

  localparam int TRCD_D = 2;
  localparam int TCAS_D = 2;
  localparam int TRAS_D = 3;
  localparam int TRP_D  = 2;

  // An overdue refresh beats an access; an open window only fills idle time.
  function automatic ramState_t arbitrate(
    input logic refPend,
    input logic refUrg,
    input logic ramReq
  );
    ramState_t pick;
    if (refPend && refUrg) begin
      pick = REF_CAS;
    end else if (ramReq) begin
      pick = ACC_RAS;
    end else if (refPend) begin
      pick = REF_CAS;
    end else begin
      pick = IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ram_refresh_arbiter.sv
// Arbitrates the DRAM array between FSB accesses and CAS-before-RAS refresh,
// driving registered strobes, the row/column mux select and the access ack.
module ram_refresh_arbiter
  import ram_pkg::*;
#(
  parameter int TRCD = TRCD_D,
  parameter int TCAS = TCAS_D,
  parameter int TRAS = TRAS_D,
  parameter int TRP  = TRP_D
) (
  input  logic CLK,
  input  logic RST,
  input  logic RefReq,
  input  logic RefUrg,
  input  logic RamReq,
  output logic RamAck,
  output logic nRAS,
  output logic nCAS,
  output logic RowSel,
  output logic RefActive,
  output logic RefMissed
);

  ramState_t  state;
  ramState_t  stateNext;
  ramState_t  arbState;
  logic [2:0] phaseCnt;
  logic [2:0] phaseCntNext;
  logic       refDone;
  logic       refDoneNext;
  logic       refDoneSet;
  logic       refReqPrev;
  logic       refPend;
  logic       refMissedNext;
  logic       nRasNext;
  logic       nCasNext;
  logic       rowSelNext;
  logic       ramAckNext;
  logic       refActiveNext;

  function automatic logic [2:0] phaseLoad(input ramState_t s);
    logic [2:0] load;
    case (s)
      ACC_RAS: load = 3'(TRCD - 1);
      ACC_CAS: load = 3'(TCAS - 1);
      REF_RAS: load = 3'(TRAS - 1);
      PRE:     load = 3'(TRP - 1);
      default: load = 3'd0;
    endcase
    return load;
  endfunction

  // Next state and phase counter; PRE re-arbitrates directly so gaps equal TRP.
  always_comb begin
    refPend      = RefReq && !refDone;
    arbState     = arbitrate(refPend, RefUrg, RamReq);
    stateNext    = state;
    phaseCntNext = phaseCnt;
    case (state)
      IDLE: begin
        stateNext    = arbState;
        phaseCntNext = phaseLoad(arbState);
      end
      ACC_RAS: begin
        if (phaseCnt == 3'd0) begin
          stateNext    = ACC_CAS;
          phaseCntNext = phaseLoad(ACC_CAS);
        end else begin
          phaseCntNext = phaseCnt - 3'd1;
        end
      end
      ACC_CAS: begin
        if (phaseCnt == 3'd0) begin
          stateNext    = PRE;
          phaseCntNext = phaseLoad(PRE);
        end else begin
          phaseCntNext = phaseCnt - 3'd1;
        end
      end
      REF_CAS: begin
        stateNext    = REF_RAS;
        phaseCntNext = phaseLoad(REF_RAS);
      end
      REF_RAS: begin
        if (phaseCnt == 3'd0) begin
          stateNext    = PRE;
          phaseCntNext = phaseLoad(PRE);
        end else begin
          phaseCntNext = phaseCnt - 3'd1;
        end
      end
      PRE: begin
        if (phaseCnt == 3'd0) begin
          stateNext    = arbState;
          phaseCntNext = phaseLoad(arbState);
        end else begin
          phaseCntNext = phaseCnt - 3'd1;
        end
      end
      default: begin
        stateNext    = IDLE;
        phaseCntNext = 3'd0;
      end
    endcase
  end

  // Refresh window bookkeeping; a window closing as the refresh ends counts as served.
  always_comb begin
    refDoneSet = (state == REF_RAS) && (phaseCnt == 3'd0);
    if (!RefReq) begin
      refDoneNext = 1'b0;
    end else if (refDoneSet) begin
      refDoneNext = 1'b1;
    end else begin
      refDoneNext = refDone;
    end
    refMissedNext = RefMissed || (!RefReq && refReqPrev && !refDone && !refDoneSet);
  end

  // Pin values decoded from the state being entered, so they register cleanly.
  always_comb begin
    nRasNext      = !(stateNext inside {ACC_RAS, ACC_CAS, REF_RAS});
    nCasNext      = !(stateNext inside {ACC_CAS, REF_CAS, REF_RAS});
    rowSelNext    = (stateNext != ACC_CAS);
    refActiveNext = (stateNext inside {REF_CAS, REF_RAS});
    ramAckNext    = (stateNext == ACC_CAS) && (phaseCntNext == 3'd0);
  end

  // State, counter, window tracking and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      phaseCnt   <= 3'd0;
      refDone    <= 1'b0;
      refReqPrev <= 1'b0;
      RefMissed  <= 1'b0;
      nRAS       <= 1'b1;
      nCAS       <= 1'b1;
      RowSel     <= 1'b1;
      RamAck     <= 1'b0;
      RefActive  <= 1'b0;
    end else begin
      state      <= stateNext;
      phaseCnt   <= phaseCntNext;
      refDone    <= refDoneNext;
      refReqPrev <= RefReq;
      RefMissed  <= refMissedNext;
      nRAS       <= nRasNext;
      nCAS       <= nCasNext;
      RowSel     <= rowSelNext;
      RamAck     <= ramAckNext;
      RefActive  <= refActiveNext;
    end
  end

endmodule

// File: tb/tb_ram_refresh_arbiter.sv
// Scoreboard bench: each scenario queues per-cycle stimulus and the expected
// registered pin pattern for the following cycle, then replays and compares.
module tb_ram_refresh_arbiter;

  logic CLK = 1'b0;
  logic RST, RefReq, RefUrg, RamReq;
  logic RamAck, nRAS, nCAS, RowSel, RefActive, RefMissed;

  ram_refresh_arbiter dut (
    .CLK(CLK), .RST(RST), .RefReq(RefReq), .RefUrg(RefUrg), .RamReq(RamReq),
    .RamAck(RamAck), .nRAS(nRAS), .nCAS(nCAS), .RowSel(RowSel),
    .RefActive(RefActive), .RefMissed(RefMissed)
  );

  always #5 CLK = ~CLK;

  // {nRAS, nCAS, RowSel, RamAck, RefActive}
  localparam logic [4:0] V_IDLE = 5'b11100;
  localparam logic [4:0] V_ARAS = 5'b01100;
  localparam logic [4:0] V_ACAS = 5'b00000;
  localparam logic [4:0] V_ACK  = 5'b00010;
  localparam logic [4:0] V_RCAS = 5'b10101;
  localparam logic [4:0] V_RRAS = 5'b00101;

  logic [3:0] stimQ[$];   // {RST, RefReq, RefUrg, RamReq}
  logic [5:0] expQ[$];    // pin pattern plus RefMissed
  logic       mexp = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic stim(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) stimQ.push_back(s);
  endtask

  task automatic expv(input logic [4:0] v);
    expQ.push_back({v, mexp});
  endtask

  task automatic exp_idle(input int n);
    for (int i = 0; i < n; i++) expv(V_IDLE);
  endtask

  task automatic exp_access();
    expv(V_ARAS); expv(V_ARAS); expv(V_ACAS); expv(V_ACK); expv(V_IDLE); expv(V_IDLE);
  endtask

  task automatic exp_refresh();
    expv(V_RCAS); expv(V_RRAS); expv(V_RRAS); expv(V_RRAS); expv(V_IDLE); expv(V_IDLE);
  endtask

  task automatic tick(output logic [5:0] act);
    logic [3:0] s;
    s = stimQ.pop_front();
    {RST, RefReq, RefUrg, RamReq} = s;
    @(posedge CLK);
    #1;
    act = {nRAS, nCAS, RowSel, RamAck, RefActive, RefMissed};
  endtask

  task automatic test_reset();
    logic [5:0] act, e;
    logic [2:0] r;
    int n;
    mexp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r = 3'($urandom_range(0, 7));
      stim({1'b1, r}, 1);
    end
    exp_idle(2);
    n = stimQ.size();
    for (int i = 0; i < n; i++) begin
      tick(act); e = expQ.pop_front(); checks++;
      if (act !== e) begin failures++; $display("FAIL reset step=%0d got=%b want=%b", i, act, e); end
    end
  endtask

  task automatic test_single_access();
    logic [5:0] act, e;
    int n;
    stim(4'b0001, 5); stim(4'b0000, 2);
    exp_access(); exp_idle(1);
    n = stimQ.size();
    for (int i = 0; i < n; i++) begin
      tick(act); e = expQ.pop_front(); checks++;
      if (act !== e) begin failures++; $display("FAIL single_access step=%0d got=%b want=%b", i, act, e); end
    end
  endtask

  task automatic test_refresh();
    logic [5:0] act, e;
    int n;
    // window held open: exactly one refresh, then close it
    stim(4'b0100, 10); stim(4'b0000, 1);
    exp_refresh(); exp_idle(5);
    // new window closing during the last REF_RAS cycle still counts as served
    stim(4'b0100, 4); stim(4'b0000, 4);
    exp_refresh(); exp_idle(2);
    n = stimQ.size();
    for (int i = 0; i < n; i++) begin
      tick(act); e = expQ.pop_front(); checks++;
      if (act !== e) begin failures++; $display("FAIL refresh step=%0d got=%b want=%b", i, act, e); end
    end
  endtask

  task automatic test_urgent_vs_access();
    logic [5:0] act, e;
    int n;
    stim(4'b0111, 11); stim(4'b0110, 2); stim(4'b0000, 1);
    exp_refresh(); exp_access(); exp_idle(2);
    n = stimQ.size();
    for (int i = 0; i < n; i++) begin
      tick(act); e = expQ.pop_front(); checks++;
      if (act !== e) begin failures++; $display("FAIL urgent_vs_access step=%0d got=%b want=%b", i, act, e); end
    end
  endtask

  task automatic test_access_then_urgent();
    logic [5:0] act, e;
    int n;
    stim(4'b0101, 1); stim(4'b0111, 4); stim(4'b0110, 8); stim(4'b0000, 1);
    exp_access(); exp_refresh(); exp_idle(2);
    n = stimQ.size();
    for (int i = 0; i < n; i++) begin
      tick(act); e = expQ.pop_front(); checks++;
      if (act !== e) begin failures++; $display("FAIL access_then_urgent step=%0d got=%b want=%b", i, act, e); end
    end
  endtask

  task automatic test_back_to_back_starvation();
    logic [5:0] act, e;
    int n;
    stim(4'b0101, 14); stim(4'b0111, 15); stim(4'b0110, 2); stim(4'b0000, 1);
    exp_access(); exp_access(); exp_access(); exp_refresh(); exp_access(); exp_idle(2);
    n = stimQ.size();
    for (int i = 0; i < n; i++) begin
      tick(act); e = expQ.pop_front(); checks++;
      if (act !== e) begin failures++; $display("FAIL back_to_back step=%0d got=%b want=%b", i, act, e); end
    end
  endtask

  task automatic test_missed();
    logic [5:0] act, e;
    int n;
    stim(4'b0101, 8); stim(4'b0001, 3); stim(4'b0000, 2);
    mexp = 1'b0;
    exp_access(); expv(V_ARAS); expv(V_ARAS);
    mexp = 1'b1;
    expv(V_ACAS); expv(V_ACK); exp_idle(3);
    // a later served window leaves the sticky flag alone
    stim(4'b0100, 10); stim(4'b0000, 1);
    exp_refresh(); exp_idle(5);
    n = stimQ.size();
    for (int i = 0; i < n; i++) begin
      tick(act); e = expQ.pop_front(); checks++;
      if (act !== e) begin failures++; $display("FAIL missed step=%0d got=%b want=%b", i, act, e); end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [5:0] act, e;
    int n;
    stim(4'b0001, 3); stim(4'b1001, 1); stim(4'b0000, 1);
    mexp = 1'b1;
    expv(V_ARAS); expv(V_ARAS); expv(V_ACAS);
    mexp = 1'b0;
    exp_idle(2);
    n = stimQ.size();
    for (int i = 0; i < n; i++) begin
      tick(act); e = expQ.pop_front(); checks++;
      if (act !== e) begin failures++; $display("FAIL reset_mid_access step=%0d got=%b want=%b", i, act, e); end
    end
  endtask

  initial begin
    RST = 1'b1; RefReq = 1'b0; RefUrg = 1'b0; RamReq = 1'b0;
    test_reset();
    test_single_access();
    test_refresh();
    test_urgent_vs_access();
    test_access_then_urgent();
    test_back_to_back_starvation();
    test_missed();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
